// File: rtl/stream_light_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_light_ctrl_if                                               |
// | Button inputs and registered control outputs of stream_light_ctrl. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface stream_light_ctrl_if;
    logic       BtnRun;
    logic       BtnStop;
    logic       BtnDir;
    logic       BtnRestart;
    logic       Run;
    logic       Stop;
    logic       Reverse;
    logic       Restart;
    logic [1:0] State;

    modport master (
        output BtnRun, BtnStop, BtnDir, BtnRestart,
        input  Run, Stop, Reverse, Restart, State
    );

    modport slave (
        input  BtnRun, BtnStop, BtnDir, BtnRestart,
        output Run, Stop, Reverse, Restart, State
    );
endinterface
`default_nettype wire

// File: rtl/stream_light_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_light_ctrl                                                  |
// | Debounced four-button control FSM for an LED stream shifter.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stream_light_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                 CLK_in,
    input  logic                 Reset,
    stream_light_ctrl_if.slave   bus
);

    localparam int              c_BTN_RUN     = 0;
    localparam int              c_BTN_STOP    = 1;
    localparam int              c_BTN_DIR     = 2;
    localparam int              c_BTN_RESTART = 3;
    localparam logic [CNT_W-1:0] c_CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_UNUSED  = 2'b11
    } state_t;

    logic [3:0] w_btn_raw;
    logic [3:0] w_deb;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] deb_dly_q;
    logic [3:0] press_q;

    assign w_btn_raw = {bus.BtnRestart, bus.BtnDir, bus.BtnStop, bus.BtnRun};

    // Press pulses are registered once more so every path has a fixed D+4 latency.
    always_ff @(posedge CLK_in or posedge Reset) begin
        if (Reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
        end else begin
            sync1_q   <= w_btn_raw;
            sync2_q   <= sync1_q;
            deb_dly_q <= w_deb;
            press_q   <= w_deb & ~deb_dly_q;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic             deb_q;

        always_ff @(posedge CLK_in or posedge Reset) begin
            if (Reset) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (sync2_q[gi] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == c_CNT_MAX) begin
                cnt_q <= '0;
                deb_q <= ~deb_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign w_deb[gi] = deb_q;
    end

    state_t state_q;
    state_t state_d;
    logic   run_q;
    logic   stop_q;
    logic   reverse_q;
    logic   reverse_d;
    logic   restart_q;
    logic   restart_req;
    logic   restart_d;

    // Priority Run > Restart > Stop; Dir is handled independently of the rest.
    always_comb begin
        state_d     = state_q;
        restart_req = 1'b0;
        reverse_d   = reverse_q ^ press_q[c_BTN_DIR];
        case (state_q)
            ST_IDLE: begin
                if (press_q[c_BTN_RUN]) begin
                    state_d     = ST_RUNNING;
                    restart_req = 1'b1;
                end
            end
            ST_RUNNING, ST_PAUSED: begin
                if (press_q[c_BTN_RUN]) begin
                    state_d = ST_IDLE;
                end else if (press_q[c_BTN_RESTART]) begin
                    state_d     = ST_RUNNING;
                    restart_req = 1'b1;
                end else if (press_q[c_BTN_STOP]) begin
                    state_d = (state_q == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                reverse_d = 1'b0;
            end
        endcase
        restart_d = restart_req & ~restart_q;
    end

    always_ff @(posedge CLK_in or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            stop_q    <= 1'b0;
            reverse_q <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= (state_d == ST_RUNNING) || (state_d == ST_PAUSED);
            stop_q    <= (state_d == ST_PAUSED);
            reverse_q <= reverse_d;
            restart_q <= restart_d;
        end
    end

    assign bus.State   = state_q;
    assign bus.Run     = run_q;
    assign bus.Stop    = stop_q;
    assign bus.Reverse = reverse_q;
    assign bus.Restart = restart_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_light_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stream_light_ctrl                                               |
// | Directed scenarios plus random buttons against a window model.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_stream_light_ctrl;

    localparam int D = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_light_ctrl_if bus();

    stream_light_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (W)
    ) dut (
        .CLK_in (clk),
        .Reset  (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a button level is accepted once the last D raw samples all show
    // the new level; the accepted rise acts on the outputs four edges later.
    typedef struct packed {
        logic [3:0][D-1:0] win;
        logic [3:0]        acc;
        logic [3:0][3:0]   dl;
        logic [1:0]        st;
        logic              rev;
        logic              rs;
    } model_t;

    model_t     m;
    logic [3:0] raw;
    logic [5:0] dut_v;
    logic [5:0] exp_v;

    assign raw   = {bus.BtnRestart, bus.BtnDir, bus.BtnStop, bus.BtnRun};
    assign dut_v = {bus.State, bus.Run, bus.Stop, bus.Reverse, bus.Restart};
    assign exp_v = {m.st, (m.st != 2'd0), (m.st == 2'd2), m.rev, m.rs};

    function automatic model_t model_step(model_t cur, logic [3:0] smp);
        model_t     nx  = cur;
        logic [3:0] ev  = '0;
        logic [3:0] eff = cur.dl[3];
        logic       rs  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            nx.win[b] = {cur.win[b][D-2:0], smp[b]};
            if (cur.acc[b] ? (nx.win[b] == '0) : (&nx.win[b])) begin
                nx.acc[b] = ~cur.acc[b];
                ev[b]     = nx.acc[b];
            end
        end
        nx.dl[3] = cur.dl[2];
        nx.dl[2] = cur.dl[1];
        nx.dl[1] = cur.dl[0];
        nx.dl[0] = ev;
        if (eff[0]) begin
            if (cur.st == 2'd0) begin
                nx.st = 2'd1;
                rs    = 1'b1;
            end else begin
                nx.st = 2'd0;
            end
        end else if (eff[3]) begin
            if (cur.st != 2'd0) begin
                nx.st = 2'd1;
                rs    = 1'b1;
            end
        end else if (eff[1]) begin
            if (cur.st == 2'd1)      nx.st = 2'd2;
            else if (cur.st == 2'd2) nx.st = 2'd1;
        end
        if (eff[2]) nx.rev = ~cur.rev;
        nx.rs = rs & ~cur.rs;
        return nx;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_step(m, raw);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (dut_v !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_held: got %b expected %b", dut_v, 6'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_v !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_release cycle %0d: got %b expected %b", i, dut_v, 6'b0);
            end
        end
    endtask

    task automatic test_run_press();
        bus.BtnRun = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) bus.BtnRun = 1'b0;
            n_cmp++;
            if (dut_v !== exp_v) begin
                n_bad++;
                $display("FAIL run_press_model cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            if (i == 7) begin
                n_cmp++;
                if (bus.State !== 2'b00) begin
                    n_bad++;
                    $display("FAIL run_press_early: state got %b expected 00", bus.State);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if ({bus.State, bus.Run, bus.Stop, bus.Restart} !== 5'b01101) begin
                    n_bad++;
                    $display("FAIL run_press_lat: got %b expected 01101",
                             {bus.State, bus.Run, bus.Stop, bus.Restart});
                end
            end
            if (i == 9) begin
                n_cmp++;
                if (bus.Restart !== 1'b0) begin
                    n_bad++;
                    $display("FAIL run_press_pulse: restart got %b expected 0", bus.Restart);
                end
            end
        end
    endtask

    task automatic test_bounce_stop();
        for (int i = 0; i < 24; i++) begin
            bus.BtnStop = (i < 12) ? (((i / 2) % 2) == 0) : 1'b0;
            tick();
            n_cmp++;
            if ({dut_v[5:2]} !== 4'b0110 || dut_v !== exp_v) begin
                n_bad++;
                $display("FAIL bounce_stop cycle %0d: got %b expected %b (state 01)", i, dut_v, exp_v);
            end
        end
        bus.BtnStop = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) bus.BtnStop = 1'b0;
            n_cmp++;
            if (dut_v !== exp_v) begin
                n_bad++;
                $display("FAIL pause_model cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            if (i == 8) begin
                n_cmp++;
                if ({bus.State, bus.Run, bus.Stop} !== 4'b1011) begin
                    n_bad++;
                    $display("FAIL pause_state: got %b expected 1011", {bus.State, bus.Run, bus.Stop});
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        bus.BtnRun  = 1'b1;
        bus.BtnStop = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) begin
                bus.BtnRun  = 1'b0;
                bus.BtnStop = 1'b0;
            end
            n_cmp++;
            if (dut_v !== exp_v || bus.Restart !== 1'b0) begin
                n_bad++;
                $display("FAIL same_cycle cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
            if (i == 7 || i == 8) begin
                n_cmp++;
                if ({bus.State, bus.Run, bus.Stop} !== ((i == 7) ? 4'b1011 : 4'b0000)) begin
                    n_bad++;
                    $display("FAIL same_cycle_state cycle %0d: got %b expected %b", i,
                             {bus.State, bus.Run, bus.Stop}, (i == 7) ? 4'b1011 : 4'b0000);
                end
            end
        end
    endtask

    task automatic test_dir_idle();
        for (int p = 0; p < 2; p++) begin
            bus.BtnDir = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (i == 10) bus.BtnDir = 1'b0;
                n_cmp++;
                if (dut_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL dir_model p%0d cycle %0d: got %b expected %b", p, i, dut_v, exp_v);
                end
                if (i == 8) begin
                    n_cmp++;
                    if (bus.Reverse !== (p == 0)) begin
                        n_bad++;
                        $display("FAIL dir_toggle p%0d: got %b expected %b", p, bus.Reverse, (p == 0));
                    end
                end
            end
        end
        bus.BtnRestart = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) bus.BtnRestart = 1'b0;
            n_cmp++;
            if (dut_v !== exp_v || {bus.State, bus.Restart} !== 3'b000) begin
                n_bad++;
                $display("FAIL idle_restart cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        bus.BtnRun = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10) bus.BtnRun = 1'b0;
            n_cmp++;
            if (dut_v !== exp_v) begin
                n_bad++;
                $display("FAIL rmid_start cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
        end
        n_cmp++;
        if (bus.State !== 2'b01) begin
            n_bad++;
            $display("FAIL rmid_running: state got %b expected 01", bus.State);
        end
        bus.BtnRestart = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dut_v !== 6'b0) begin
            n_bad++;
            $display("FAIL rmid_async: got %b expected %b", dut_v, 6'b0);
        end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++;
            if (dut_v !== exp_v || {bus.State, bus.Restart} !== 3'b000) begin
                n_bad++;
                $display("FAIL rmid_after cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
        end
        bus.BtnRestart = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int         hold [4];
        logic [3:0] lvl;
        logic       prev_rs;
        lvl     = '0;
        prev_rs = 1'b0;
        for (int b = 0; b < 4; b++) hold[b] = 0;
        for (int c = 0; c < 1200; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 2 * D + 3);
                end
                hold[b]--;
            end
            bus.BtnRun     = lvl[0];
            bus.BtnStop    = lvl[1];
            bus.BtnDir     = lvl[2];
            bus.BtnRestart = lvl[3];
            rst            = ($urandom_range(0, 299) == 0);
            tick();
            n_cmp++;
            if (dut_v !== exp_v) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %b expected %b", c, dut_v, exp_v);
            end
            n_cmp++;
            if (bus.Restart === 1'b1 && prev_rs) begin
                n_bad++;
                $display("FAIL restart_width cycle %0d: got 2-cycle pulse expected 1", c);
            end
            prev_rs = bus.Restart;
        end
        rst            = 1'b0;
        bus.BtnRun     = 1'b0;
        bus.BtnStop    = 1'b0;
        bus.BtnDir     = 1'b0;
        bus.BtnRestart = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (dut_v !== exp_v) begin
                n_bad++;
                $display("FAIL random_drain cycle %0d: got %b expected %b", i, dut_v, exp_v);
            end
        end
    endtask

    initial begin
        bus.BtnRun     = 1'b0;
        bus.BtnStop    = 1'b0;
        bus.BtnDir     = 1'b0;
        bus.BtnRestart = 1'b0;
        test_reset();
        test_run_press();
        test_bounce_stop();
        test_same_cycle();
        test_dir_idle();
        test_reset_mid_debounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_light_ctrl.md
STREAM_LIGHT_CTRL -- requirements
Module: stream_light_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz).
REQ-002 Parameter CNT_W, default 20, is the debounce counter width and SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 CLK_in  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 BtnRun  input  1  raw push button, active-high, asynchronous, bouncing; each press toggles power on/off.
REQ-006 BtnStop  input  1  raw push button; each press toggles pause.
REQ-007 BtnDir  input  1  raw push button; each press toggles shift direction.
REQ-008 BtnRestart  input  1  raw push button; each press requests a pattern restart.
REQ-009 Run  output  1  registered; high in RUNNING and PAUSED.
REQ-010 Stop  output  1  registered; high only in PAUSED.
REQ-011 Reverse  output  1  registered direction flag; 1 = shift right.
REQ-012 Restart  output  1  registered one-cycle pulse; the downstream shifter reloads LED = 16'h0001.
REQ-013 State  output  2  registered FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED; 11 is unused.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each button SHALL have an independent debouncer: a counter that increments while the synchronized level differs from the debounced level, clears when they match, and flips the debounced level when it reaches DEBOUNCE_CYCLES-1.
REQ-016 A rising edge of a debounced level SHALL produce a one-cycle press pulse; falling edges and held levels SHALL produce nothing.
REQ-017 Latency SHALL be exactly DEBOUNCE_CYCLES+4 cycles from a raw level change (held stable) to the resulting output change.
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES cycles SHALL produce no press.
REQ-019 IDLE, Run press: go to RUNNING and assert Restart for one cycle.
REQ-020 RUNNING, Run press: go to IDLE.
REQ-021 RUNNING, Stop press: go to PAUSED.
REQ-022 PAUSED, Run press: go to IDLE.
REQ-023 PAUSED, Stop press: go to RUNNING.
REQ-024 IDLE: Stop and Restart presses are ignored.
REQ-025 RUNNING or PAUSED, Restart press: assert Restart for one cycle and go to RUNNING.
REQ-026 Same-cycle presses SHALL resolve with priority Run > Restart > Stop; lower-priority presses in that cycle are discarded.
REQ-027 A Dir press SHALL toggle Reverse in every state, independent of the other presses in the same cycle.
REQ-028 Reverse SHALL be retained across IDLE.
REQ-029 Outputs SHALL be decoded from the next state and registered, so Run, Stop and State change in the same cycle.
REQ-030 Restart SHALL never be high for more than one consecutive cycle.
REQ-031 State 11 SHALL recover to IDLE on the next clock with all outputs 0.

Reset
REQ-032 While Reset = 1, regardless of clock: State = IDLE, Run = Stop = Reverse = Restart = 0, all synchronizer flops, debounced levels and counters = 0.
REQ-033 A button held high across the release of Reset SHALL register as exactly one press, DEBOUNCE_CYCLES+4 cycles after release.
REQ-034 Reset asserted mid-debounce SHALL discard the partial count; no press is generated for it.

Verification (DEBOUNCE_CYCLES = 4)
REQ-035 After reset, hold BtnRun high for 10 cycles -> 8 cycles after the rising edge, Run=1, Stop=0, State=01, Restart=1 for exactly one cycle.
REQ-036 In RUNNING, toggle BtnStop every 2 cycles for 12 cycles, then hold low -> no state change; then a clean 10-cycle BtnStop press -> State=10, Stop=1, Run=1.
REQ-037 In PAUSED, press BtnRun and BtnStop in the same cycle -> State=00, Run=0, Stop=0, Restart=0.
REQ-038 In IDLE, press BtnDir twice, then BtnRestart -> Reverse toggles 0->1->0, State stays 00, Restart stays 0.
REQ-039 In RUNNING, assert Reset for 1 cycle during a BtnRestart debounce (count = 2) -> all outputs 0 immediately, no Restart pulse follows; with BtnRestart still held, the bench observes one press after DEBOUNCE_CYCLES+4 cycles, ignored in IDLE.
